pcpi_modq_engine: RTL
=====================

# pcpi_modq_engine

Parametrised modular-arithmetic coprocessor on the PicoRV32 PCPI bus. It is the next generation of the custom ADDMOD/SUBMOD/MODQ unit: modulus, modulus width and data width are generic, and it adds a sequential MULMOD (interleaved shift-add modular multiply). It sits beside the M-extension coprocessor on the shared PCPI port. It claims only the custom-opcode instructions listed below.

## Interface
- `XLEN`, 32: data width of `pcpi_rs1`, `pcpi_rs2` and `pcpi_rd`.
- `Q_WIDTH`, 14: width of the modulus and of the internal remainder register. Must satisfy `Q_WIDTH <= XLEN`.
- `Q`, 3329: modulus. Must satisfy `2 <= Q < 2**Q_WIDTH`.
- `OPCODE`, 7'b0001011: claimed major opcode (custom-0).
- `FUNC7`, 7'b0000000: required `insn[31:25]`.
- `clk  in  1`: the single clock; all state changes on its rising edge.
- `reset  in  1`: synchronous, active-high reset.
- `pcpi_valid  in  1`: instruction offered by the core; held high until `pcpi_ready`.
- `pcpi_insn  in  32`: the instruction word.
- `pcpi_rs1  in  XLEN`: operand a.
- `pcpi_rs2  in  XLEN`: operand b.
- `pcpi_wr  out  1`: write-back request; pulses together with `pcpi_ready`.
- `pcpi_rd  out  XLEN`: result, zero-extended from `Q_WIDTH`.
- `pcpi_busy  out  1`: instruction claimed and in progress.
- `pcpi_ready  out  1`: one-cycle completion pulse.

## Operation
- Decode, accepted only when `opcode==OPCODE` and `func7==FUNC7`:
  - func3 000 = ADDMOD
  - func3 001 = SUBMOD
  - func3 010 = MODQ
  - func3 011 = MULMOD
  - Any other func3, opcode or func7 is unclaimed: stay IDLE with busy, ready and wr all 0.
- FSM states: IDLE, REDUCE, MULT, DONE.
  - Reset forces IDLE, clears the counter, remainder `r`, latched `a` and result, and drives all outputs to 0.
- IDLE:
  - ADDMOD and SUBMOD compute in one step and go to DONE.
  - MODQ latches rs1, clears `r` and goes to REDUCE.
  - MULMOD latches rs1 and rs2, clears `r` and goes to REDUCE.
  - Counter loads `XLEN-1`.
- ADDMOD:
  - `s = rs1[Q_WIDTH-1:0] + rs2[Q_WIDTH-1:0]` (Q_WIDTH+1 bits).
  - Result = `s >= Q ? s-Q : s`.
- SUBMOD:
  - `d = rs1[Q_WIDTH-1:0] - rs2[Q_WIDTH-1:0]` (Q_WIDTH+1 bits, signed).
  - Result = `d < 0 ? d+Q : d`.
- ADDMOD and SUBMOD are correct only for operands < Q. For out-of-range operands the block still produces exactly the formula above, and the bench checks against that formula.
- REDUCE (restoring reduction, MSB first), once per cycle for i = XLEN-1 down to 0:
  - `t = {r,rs1[i]}`
  - `r = t >= Q ? t-Q : t`
  - `r` is Q_WIDTH+1 bits internally. The invariant `r < Q` holds after every step.
  - At i==0:
    - MODQ: result = `r`, go to DONE.
    - MULMOD: `a = r`, clear `r`, reload counter to `XLEN-1`, go to MULT.
- MULT (interleaved modular multiply), once per cycle for i = XLEN-1 down to 0:
  - `u = 2r`, then `u = u >= Q ? u-Q : u`
  - `v = u + (rs2[i] ? a : 0)`, then `v = v >= Q ? v-Q : v`
  - `r = v`
  - At i==0: result = `r`, go to DONE.
- DONE:
  - `pcpi_ready=1`, `pcpi_wr=1`, `pcpi_rd` = result.
  - Next state is IDLE unconditionally.
  - No new instruction is sampled in DONE.
- Abort: if `pcpi_valid` is 0 in REDUCE or MULT, go to IDLE next cycle. No ready is issued, and the result is discarded.
- `pcpi_busy` = 1 in REDUCE and MULT, 0 otherwise.
- `pcpi_rd` = 0 outside DONE.

## Timing
- Instruction sampled on the edge ending cycle 0, i.e. `pcpi_valid` high in IDLE.
- ADDMOD and SUBMOD: ready and wr in cycle 1. Busy never asserts.
- MODQ: busy in cycles 1..XLEN, ready in cycle XLEN+1. For XLEN=32 that is cycle 33.
- MULMOD: busy in cycles 1..2·XLEN, ready in cycle 2·XLEN+1. For XLEN=32 that is cycle 65.
- Back-to-back instructions: the earliest next acceptance is the cycle after DONE, provided `pcpi_valid` is high there.
- Reset has priority over all other events. Asserting it in any state (including DONE) yields IDLE with all outputs 0 on the next cycle, and no ready pulse.
- Operands are latched at acceptance. Changes on rs1 or rs2 during busy have no effect.

## Test plan
- ADDMOD rs1=3000, rs2=500 → pcpi_rd=171 in cycle 1; ready and wr high for exactly one cycle; busy stays 0.
- SUBMOD rs1=5, rs2=10 → 3324. Also SUBMOD 7,7 → 0. Also ADDMOD 3328,1 → 0.
- MODQ rs1=0xFFFFFFFF → 1352 at cycle 33. MODQ rs1=3328 → 3328. MODQ rs1=3329 → 0.
- MULMOD rs1=3328, rs2=3328 → 1 at cycle 65. MULMOD rs1=100000, rs2=2 → 260 (100000 mod Q = 130). MULMOD rs2=0 → 0.
- Reset asserted in cycle 10 of MULMOD → busy=0 and ready never pulses. Then a fresh MODQ rs1=6658 → 0 at cycle 33.
- Abort and unclaimed cases:
  - Drop pcpi_valid in cycle 5 of MODQ → IDLE with no ready.
  - func3=3'b111, or func7≠FUNC7, held valid for 100 cycles → busy, ready and wr stay 0 throughout.

Source files
------------

// File: rtl/pcpi_modq_engine_if.sv
// PCPI bus bundle between the core (master) and a coprocessor (slave).
interface pcpi_modq_engine_if #(
   parameter int unsigned XLEN = 32
);
   logic            pcpi_valid;
   logic [31:0]     pcpi_insn;
   logic [XLEN-1:0] pcpi_rs1;
   logic [XLEN-1:0] pcpi_rs2;
   logic            pcpi_wr;
   logic [XLEN-1:0] pcpi_rd;
   logic            pcpi_busy;
   logic            pcpi_ready;

   modport master (
      output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
      input  pcpi_wr, pcpi_rd, pcpi_busy, pcpi_ready
   );

   modport slave (
      input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
      output pcpi_wr, pcpi_rd, pcpi_busy, pcpi_ready
   );
endinterface

// File: rtl/pcpi_modq_engine.sv
// Modular-arithmetic PCPI coprocessor: ADDMOD, SUBMOD, MODQ and sequential MULMOD
// against a fixed modulus Q, using bit-serial restoring reduction.
module pcpi_modq_engine #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned Q_WIDTH = 14,
   parameter int unsigned Q       = 3329,
   parameter logic [6:0]  OPCODE  = 7'b0001011,
   parameter logic [6:0]  FUNC7   = 7'b0000000
) (
   input logic               clk,
   input logic               reset,
   pcpi_modq_engine_if.slave pcpi
);
   localparam int unsigned CW      = (XLEN > 1) ? $clog2(XLEN) : 1;
   localparam int unsigned RW      = Q_WIDTH + 1;
   localparam logic [RW-1:0] QV    = RW'(Q);
   localparam logic [CW-1:0] CNT_TOP = CW'(XLEN - 1);

   typedef enum logic [1:0] {IDLE, REDUCE, MULT, DONE} state_t;

   state_t              state, state_n;
   logic [CW-1:0]       cnt, cnt_n;
   logic [RW-1:0]       r, r_n;
   logic [Q_WIDTH-1:0]  a, a_n;
   logic [Q_WIDTH-1:0]  result, result_n;
   logic [XLEN-1:0]     x, x_n;
   logic [XLEN-1:0]     y, y_n;
   logic                is_mul, is_mul_n;

   logic                busy_q, ready_q, wr_q;
   logic [XLEN-1:0]     rd_q;

   logic [6:0]          opcode_c, func7_c;
   logic [2:0]          func3_c;
   logic                claimed_c;
   logic                unused_insn_c;

   logic [RW-1:0]       add_s_c, add_res_c, sub_d_c, sub_res_c;
   logic [RW-1:0]       red_r_c, mul_u_c, mul_v_c;

   function automatic logic [RW-1:0] cond_sub(input logic [RW-1:0] t);
      return (t >= QV) ? t - QV : t;
   endfunction

   // Instruction decode
   always_comb begin
      opcode_c      = pcpi.pcpi_insn[6:0];
      func3_c       = pcpi.pcpi_insn[14:12];
      func7_c       = pcpi.pcpi_insn[31:25];
      claimed_c     = (opcode_c == OPCODE) && (func7_c == FUNC7) && !func3_c[2];
      unused_insn_c = ^{pcpi.pcpi_insn[24:15], pcpi.pcpi_insn[11:7]};
   end

   // Datapath: single-step add/sub and one reduction / multiply step per cycle
   always_comb begin
      add_s_c   = {1'b0, pcpi.pcpi_rs1[Q_WIDTH-1:0]} + {1'b0, pcpi.pcpi_rs2[Q_WIDTH-1:0]};
      add_res_c = cond_sub(add_s_c);
      sub_d_c   = {1'b0, pcpi.pcpi_rs1[Q_WIDTH-1:0]} - {1'b0, pcpi.pcpi_rs2[Q_WIDTH-1:0]};
      sub_res_c = sub_d_c[Q_WIDTH] ? sub_d_c + QV : sub_d_c;
      red_r_c   = cond_sub({r[Q_WIDTH-1:0], x[cnt]});
      mul_u_c   = cond_sub({r[Q_WIDTH-1:0], 1'b0});
      mul_v_c   = cond_sub(mul_u_c + (y[cnt] ? {1'b0, a} : RW'(0)));
   end

   // Next-state logic
   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      r_n      = r;
      a_n      = a;
      result_n = result;
      x_n      = x;
      y_n      = y;
      is_mul_n = is_mul;
      case (state)
         IDLE: begin
            if (pcpi.pcpi_valid && claimed_c) begin
               cnt_n = CNT_TOP;
               case (func3_c[1:0])
                  2'b00: begin
                     result_n = add_res_c[Q_WIDTH-1:0];
                     state_n  = DONE;
                  end
                  2'b01: begin
                     result_n = sub_res_c[Q_WIDTH-1:0];
                     state_n  = DONE;
                  end
                  2'b10: begin
                     x_n      = pcpi.pcpi_rs1;
                     r_n      = '0;
                     is_mul_n = 1'b0;
                     state_n  = REDUCE;
                  end
                  default: begin
                     x_n      = pcpi.pcpi_rs1;
                     y_n      = pcpi.pcpi_rs2;
                     r_n      = '0;
                     is_mul_n = 1'b1;
                     state_n  = REDUCE;
                  end
               endcase
            end
         end
         REDUCE: begin
            if (!pcpi.pcpi_valid) begin
               state_n = IDLE;
            end else if (cnt == '0) begin
               if (is_mul) begin
                  a_n     = red_r_c[Q_WIDTH-1:0];
                  r_n     = '0;
                  cnt_n   = CNT_TOP;
                  state_n = MULT;
               end else begin
                  r_n      = red_r_c;
                  result_n = red_r_c[Q_WIDTH-1:0];
                  state_n  = DONE;
               end
            end else begin
               r_n   = red_r_c;
               cnt_n = cnt - CW'(1);
            end
         end
         MULT: begin
            if (!pcpi.pcpi_valid) begin
               state_n = IDLE;
            end else begin
               r_n = mul_v_c;
               if (cnt == '0) begin
                  result_n = mul_v_c[Q_WIDTH-1:0];
                  state_n  = DONE;
               end else begin
                  cnt_n = cnt - CW'(1);
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         r       <= '0;
         a       <= '0;
         result  <= '0;
         x       <= '0;
         y       <= '0;
         is_mul  <= 1'b0;
         busy_q  <= 1'b0;
         ready_q <= 1'b0;
         wr_q    <= 1'b0;
         rd_q    <= '0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         r       <= r_n;
         a       <= a_n;
         result  <= result_n;
         x       <= x_n;
         y       <= y_n;
         is_mul  <= is_mul_n;
         busy_q  <= (state_n == REDUCE) || (state_n == MULT);
         ready_q <= (state_n == DONE);
         wr_q    <= (state_n == DONE);
         rd_q    <= (state_n == DONE) ? XLEN'(result_n) : '0;
      end
   end

   assign pcpi.pcpi_busy  = busy_q;
   assign pcpi.pcpi_ready = ready_q;
   assign pcpi.pcpi_wr    = wr_q;
   assign pcpi.pcpi_rd    = rd_q;
endmodule
